// File: rtl/alu_fu_if.sv
// alu_fu_if: issue/result bundle between reservation station, ALU FU and CDB.
interface alu_fu_if #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [ROB_W-1:0]  in_rob_tag;
    logic [11:0]       in_opcode;
    logic [3:0]        in_aluop;
    logic              in_is_beq;
    logic              in_is_bne;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              cdb_grant;
    logic              out_valid;
    logic [DATA_W-1:0] out_res;
    logic              out_branch_taken;
    logic [ROB_W-1:0]  out_rob_tag;
    logic [11:0]       out_opcode;
    logic              fu_is_free;

    modport master (
        output flush, in_valid, in_rob_tag, in_opcode, in_aluop, in_is_beq, in_is_bne, in_a, in_b, cdb_grant,
        input  in_ready, out_valid, out_res, out_branch_taken, out_rob_tag, out_opcode, fu_is_free
    );
    modport slave (
        input  flush, in_valid, in_rob_tag, in_opcode, in_aluop, in_is_beq, in_is_bne, in_a, in_b, cdb_grant,
        output in_ready, out_valid, out_res, out_branch_taken, out_rob_tag, out_opcode, fu_is_free
    );
endinterface

// File: rtl/alu_fu_pipe.sv
// alu_fu_pipe: ALU functional unit, result computed at issue then carried through STAGES slots to the CDB.
// Define ALU_FU_EXT_OPS_EN to add aluop 10 (sra), 11 (sltu), 12 (lui).
module alu_fu_pipe #(
    parameter int DATA_W = 32,
    parameter int ROB_W  = 5,
    parameter int STAGES = 2
) (
    input logic   clk,
    input logic   rst,
    alu_fu_if.slave f
);
    localparam int SH_W = $clog2(DATA_W);

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [ROB_W-1:0]  tag;
        logic [11:0]       op;
        logic              br;
    } slot_t;

    slot_t [STAGES-1:0] sl_q;
    slot_t              in_sl;
    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  mv;
    logic [SH_W-1:0]    sh;
    logic [DATA_W-1:0]  res;
    logic               br;
    logic               acc;

    assign sh = f.in_b[SH_W-1:0];
    assign br = (f.in_is_beq & (f.in_a == f.in_b)) | (f.in_is_bne & (f.in_a != f.in_b));
    assign in_sl = {res, f.in_rob_tag, f.in_opcode, br};

    always_comb begin
        case (f.in_aluop)
            4'd0:    res = f.in_a + f.in_b;
            4'd1:    res = f.in_a - f.in_b;
            4'd2:    res = f.in_a & f.in_b;
            4'd3:    res = f.in_a | f.in_b;
            4'd4:    res = f.in_a ^ f.in_b;
            4'd5:    res = ~(f.in_a | f.in_b);
            4'd6:    res = f.in_a << sh;
            4'd7:    res = f.in_a >> sh;
            4'd8:    res = DATA_W'($signed(f.in_a) < $signed(f.in_b));
            4'd9:    res = DATA_W'($signed(f.in_a) > $signed(f.in_b));
`ifdef ALU_FU_EXT_OPS_EN
            4'd10:   res = DATA_W'($signed(f.in_a) >>> sh);
            4'd11:   res = DATA_W'(f.in_a < f.in_b);
            4'd12:   res = f.in_b << 16;
`endif
            default: res = '0;
        endcase
    end

    // A slot moves when the output advances or when it or any later slot holds a bubble.
    always_comb begin
        mv = '0;
        acc = !v_q[STAGES-1] | f.cdb_grant;
        mv[STAGES-1] = acc;
        for (int i = STAGES - 2; i >= 0; i--) begin
            acc = !v_q[i] | acc;
            mv[i] = acc;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            sl_q <= '0;
        end else begin
            if (mv[0]) begin
                sl_q[0] <= in_sl;
                v_q[0]  <= f.in_valid;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (mv[i]) begin
                    sl_q[i] <= sl_q[i-1];
                    v_q[i]  <= v_q[i-1];
                end
            end
            if (f.flush) v_q <= '0;
        end
    end

    assign f.in_ready         = mv[0];
    assign f.fu_is_free       = mv[0];
    assign f.out_valid        = v_q[STAGES-1];
    assign f.out_res          = sl_q[STAGES-1].res;
    assign f.out_rob_tag      = sl_q[STAGES-1].tag;
    assign f.out_opcode       = sl_q[STAGES-1].op;
    assign f.out_branch_taken = sl_q[STAGES-1].br;
endmodule

// File: tb/tb_alu_fu_pipe.sv
// tb_alu_fu_pipe: directed bench for alu_fu_pipe with an in-order result queue model.
module tb_alu_fu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pat_en = 1'b0;
    int   cyc = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic [11:0] op;
        logic        br;
    } exp_t;
    exp_t q[$];

    alu_fu_if #(.DATA_W(32), .ROB_W(5)) f ();
    alu_fu_pipe #(.DATA_W(32), .ROB_W(5), .STAGES(2)) dut (.clk(clk), .rst(rst), .f(f));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = int'(b % 32);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ~(a | b);
            4'd6: return a << sa;
            4'd7: return a >> sa;
            4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
`ifdef ALU_FU_EXT_OPS_EN
            4'd10: return a[31] ? ~((~a) >> sa) : a >> sa;
            4'd11: return (a < b) ? 32'd1 : 32'd0;
            4'd12: return b * 32'd65536;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Reference: every accepted op is appended; every granted output retires the oldest.
    always @(negedge clk or posedge rst) begin
        if (rst || f.flush) q.delete();
        else begin
            if (f.out_valid && f.cdb_grant) void'(q.pop_front());
            if (f.in_valid && f.in_ready)
                q.push_back('{alu_model(f.in_aluop, f.in_a, f.in_b), f.in_rob_tag, f.in_opcode,
                              (f.in_is_beq && f.in_a == f.in_b) || (f.in_is_bne && f.in_a != f.in_b)});
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            n_cmp++;
            if (f.in_ready !== f.fu_is_free) begin
                n_bad++;
                $display("FAIL free_eq_ready: fu_is_free=%b in_ready=%b", f.fu_is_free, f.in_ready);
            end
            if (f.out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stray_out: tag=%0d with nothing outstanding", f.out_rob_tag);
                end else if ({f.out_res, f.out_rob_tag, f.out_opcode, f.out_branch_taken} !== q[0]) begin
                    n_bad++;
                    $display("FAIL model_out: got res=%h tag=%0d op=%h br=%b exp res=%h tag=%0d op=%h br=%b",
                             f.out_res, f.out_rob_tag, f.out_opcode, f.out_branch_taken,
                             q[0].res, q[0].tag, q[0].op, q[0].br);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (pat_en) begin
            cyc++;
            f.cdb_grant = (cyc % 3) != 0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] aluop, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [11:0] opc, input logic beq, input logic bne);
        f.in_aluop = aluop; f.in_a = a; f.in_b = b; f.in_rob_tag = tag;
        f.in_opcode = opc; f.in_is_beq = beq; f.in_is_bne = bne; f.in_valid = 1'b1;
    endtask

    task automatic send(input logic [3:0] aluop, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input logic [11:0] opc, input logic beq, input logic bne);
        int n;
        set_in(aluop, a, b, tag, opc, beq, bne);
        n = 0;
        #1;
        while (!f.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            n_bad++;
            $display("FAIL send_timeout: tag %0d never accepted", tag);
        end
        @(posedge clk);
        f.in_valid = 1'b0;
    endtask

    task automatic expect_next(input string nm, input logic [31:0] res, input logic [4:0] tag, input logic br);
        int n;
        n = 0;
        while (!f.out_valid && n < 20) begin
            @(posedge clk); n++;
        end
        chk({nm, "_valid"}, 64'(f.out_valid), 64'd1);
        chk({nm, "_res"}, 64'(f.out_res), 64'(res));
        chk({nm, "_tag"}, 64'(f.out_rob_tag), 64'(tag));
        chk({nm, "_br"}, 64'(f.out_branch_taken), 64'(br));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        int acc;
        f.flush = 1'b0; f.cdb_grant = 1'b1; f.in_valid = 1'b0;
        set_in(4'd0, 32'd0, 32'd0, 5'd0, 12'd0, 1'b0, 1'b0);
        f.in_valid = 1'b0;
        #3;
        chk("rst_out_valid", 64'(f.out_valid), 64'd0);
        chk("rst_out_res", 64'(f.out_res), 64'd0);
        chk("rst_in_ready", 64'(f.in_ready), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        // add latency: valid exactly STAGES negedges after issue
        set_in(4'd0, 32'd5, 32'd7, 5'd3, 12'h013, 1'b0, 1'b0);
        @(posedge clk);
        f.in_valid = 1'b0;
        chk("add_lat1", 64'(f.out_valid), 64'd0);
        @(posedge clk);
        chk("add_valid", 64'(f.out_valid), 64'd1);
        chk("add_res", 64'(f.out_res), 64'd12);
        chk("add_tag", 64'(f.out_rob_tag), 64'd3);
        @(posedge clk);
        chk("add_gone", 64'(f.out_valid), 64'd0);
        // slt / sgt back to back
        send(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd4, 12'h033, 1'b0, 1'b0);
        send(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd5, 12'h033, 1'b0, 1'b0);
        expect_next("slt", 32'd1, 5'd4, 1'b0);
        @(posedge clk);
        chk("sgt_valid", 64'(f.out_valid), 64'd1);
        chk("sgt_res", 64'(f.out_res), 64'd0);
        idle(3);
        // CDB stall while issuing continuously
        f.cdb_grant = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            set_in(4'd0, 32'(100 + acc), 32'd0, 5'(10 + acc), 12'h033, 1'b0, 1'b0);
            #1;
            if (f.in_ready) acc++;
            @(posedge clk);
        end
        f.in_valid = 1'b0;
        chk("stall_accepted", 64'(acc), 64'd2);
        chk("stall_ready", 64'(f.in_ready), 64'd0);
        chk("stall_hold_tag", 64'(f.out_rob_tag), 64'd10);
        chk("stall_hold_res", 64'(f.out_res), 64'd100);
        f.cdb_grant = 1'b1;
        send(4'd0, 32'd102, 32'd0, 5'd12, 12'h033, 1'b0, 1'b0);
        send(4'd0, 32'd103, 32'd0, 5'd13, 12'h033, 1'b0, 1'b0);
        idle(4);
        chk("stall_drained", 64'(q.size()), 64'd0);
        // branch qualifiers
        send(4'd1, 32'd4, 32'd4, 5'd1, 12'h063, 1'b0, 1'b1);
        expect_next("bne", 32'd0, 5'd1, 1'b0);
        idle(2);
        send(4'd1, 32'd4, 32'd4, 5'd2, 12'h063, 1'b1, 1'b0);
        expect_next("beq", 32'd0, 5'd2, 1'b1);
        idle(2);
        // flush with two ops in flight and a colliding issue
        f.cdb_grant = 1'b0;
        send(4'd0, 32'd1, 32'd1, 5'd20, 12'h033, 1'b0, 1'b0);
        send(4'd0, 32'd2, 32'd2, 5'd21, 12'h033, 1'b0, 1'b0);
        f.flush = 1'b1; f.cdb_grant = 1'b1;
        set_in(4'd0, 32'd3, 32'd3, 5'd22, 12'h033, 1'b0, 1'b0);
        @(posedge clk);
        f.flush = 1'b0; f.in_valid = 1'b0;
        chk("flush_valid", 64'(f.out_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            chk("flush_quiet", 64'(f.out_valid), 64'd0);
        end
        // async reset mid-pipeline
        f.cdb_grant = 1'b0;
        send(4'd0, 32'd4, 32'd4, 5'd30, 12'h7AB, 1'b1, 1'b0);
        send(4'd3, 32'd9, 32'd6, 5'd31, 12'h7AB, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(f.out_valid), 64'd0);
        chk("arst_res", 64'(f.out_res), 64'd0);
        chk("arst_tag", 64'(f.out_rob_tag), 64'd0);
        chk("arst_opcode", 64'(f.out_opcode), 64'd0);
        chk("arst_br", 64'(f.out_branch_taken), 64'd0);
        chk("arst_ready", 64'(f.in_ready), 64'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        f.cdb_grant = 1'b1;
        send(4'd10, 32'h8000_0000, 32'd4, 5'd7, 12'h033, 1'b0, 1'b0);
`ifdef ALU_FU_EXT_OPS_EN
        expect_next("sra", 32'hF800_0000, 5'd7, 1'b0);
`else
        expect_next("sra", 32'h0, 5'd7, 1'b0);
`endif
        idle(2);
        // op mix under a periodic CDB stall pattern
        pat_en = 1'b1;
        send(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1, 12'h001, 1'b0, 1'b0);
        send(4'd1, 32'd0, 32'd1, 5'd2, 12'h002, 1'b0, 1'b0);
        send(4'd2, 32'h0000_F0F0, 32'h0000_FF00, 5'd3, 12'h003, 1'b0, 1'b1);
        send(4'd3, 32'h0000_F0F0, 32'h0000_FF00, 5'd4, 12'h004, 1'b1, 1'b0);
        send(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 5'd5, 12'h005, 1'b0, 1'b0);
        send(4'd5, 32'd0, 32'd0, 5'd6, 12'h006, 1'b1, 1'b0);
        send(4'd6, 32'd1, 32'd33, 5'd7, 12'h007, 1'b0, 1'b0);
        send(4'd7, 32'h8000_0000, 32'd31, 5'd8, 12'h008, 1'b0, 1'b0);
        send(4'd8, 32'd1, 32'hFFFF_FFFF, 5'd9, 12'h009, 1'b0, 1'b0);
        send(4'd9, 32'd1, 32'hFFFF_FFFF, 5'd10, 12'h00A, 1'b0, 1'b0);
        send(4'd11, 32'd1, 32'hFFFF_FFFF, 5'd11, 12'h00B, 1'b0, 1'b0);
        send(4'd12, 32'd0, 32'h0000_1234, 5'd12, 12'h00C, 1'b0, 1'b0);
        send(4'd13, 32'd5, 32'd5, 5'd13, 12'h00D, 1'b0, 1'b1);
        send(4'd15, 32'd5, 32'd6, 5'd14, 12'h00E, 1'b0, 1'b1);
        pat_en = 1'b0;
        f.cdb_grant = 1'b1;
        idle(6);
        chk("mix_drained", 64'(q.size()), 64'd0);
        chk("mix_idle", 64'(f.out_valid), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/alu_fu_pipe.md
ALU_FU_PIPE -- requirements
Module: alu_fu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width (min 8).
REQ-002 SHALL have parameter ROB_W, default 5, ROB tag width (ROB_SIZE_bits+1).
REQ-003 SHALL have parameter STAGES, default 2, pipeline depth (min 1).
REQ-004 SHALL have port clk  in  1  FU clock; all registers update on negedge clk.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  in  1  kill all in-flight ops (mispredict).
REQ-007 SHALL have port in_valid  in  1  issue request from RS.
REQ-008 SHALL have port in_ready  out  1  FU accepts issue this cycle.
REQ-009 SHALL have port in_rob_tag  in  ROB_W  destination ROB entry.
REQ-010 SHALL have port in_opcode  in  12  opcode, carried to output.
REQ-011 SHALL have port in_aluop  in  4  operation select.
REQ-012 SHALL have port in_is_beq / in_is_bne  in  1 each  branch qualifiers.
REQ-013 SHALL have port in_a, in_b  in  DATA_W each  operands.
REQ-014 SHALL have port cdb_grant  in  1  CDB accepts current output.
REQ-015 SHALL have port out_valid  out  1  result pending on CDB.
REQ-016 SHALL have port out_res  out  DATA_W  result.
REQ-017 SHALL have port out_branch_taken  out  1  branch decision.
REQ-018 SHALL have port out_rob_tag  out  ROB_W; out_opcode  out  12.
REQ-019 SHALL have port fu_is_free  out  1  equals in_ready.

Function
REQ-020 SHALL decode aluop: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 shl A by B, 7 shr logical, 8 signed slt, 9 signed sgt; all other codes give 0 (unless REQ-033).
REQ-021 SHALL use only low clog2(DATA_W) bits of B as shift amount; add/sub wrap modulo 2^DATA_W.
REQ-022 SHALL compute branch_taken = (is_beq & A==B) | (is_bne & A!=B), independent of aluop.
REQ-023 SHALL compute result combinationally at issue and carry it with tag/opcode/branch through STAGES register slots, each with a valid bit.
REQ-024 SHALL define advance = !out_valid | cdb_grant; when advance, every slot shifts one stage toward output; otherwise all slots hold.
REQ-025 SHALL drive in_ready = advance | any slot empty (bubble collapse: a slot loads if it or any later slot is empty).
REQ-026 SHALL accept an op on a clock edge where in_valid & in_ready & !flush; latency issue-to-out_valid = STAGES edges with no stall.
REQ-027 SHALL sustain one op per cycle with cdb_grant held high; no op lost or duplicated under any stall pattern.
REQ-028 SHALL keep out_res/out_rob_tag/out_opcode/out_branch_taken stable while out_valid & !cdb_grant.
REQ-029 SHALL, on flush at an edge, clear all valid bits and drop any simultaneous issue; flush has priority over cdb_grant and in_valid.
REQ-030 SHALL ignore cdb_grant when out_valid is 0.

Reset
REQ-031 SHALL, while rst high, force all valid bits, out_res, out_rob_tag, out_opcode, out_branch_taken to 0 immediately; in_ready=1 after reset.
REQ-032 SHALL discard in-flight ops on rst mid-operation; first edge after rst deassertion may accept an issue.

Configuration
REQ-033 SHALL, with macro ALU_FU_EXT_OPS_EN defined, add aluop 10 = arithmetic shift right, 11 = unsigned sltu, 12 = lui (B << 16); without it, codes 10-12 give 0 like other undefined codes.

Verification
REQ-034 SHALL test: STAGES=2, issue add A=5,B=7,tag=3, cdb_grant=1 -> out_valid on 2nd negedge, out_res=12, out_rob_tag=3.
REQ-035 SHALL test: issue slt A=0xFFFFFFFF,B=1 then sgt same operands back-to-back -> results 1 then 0 on consecutive cycles.
REQ-036 SHALL test: cdb_grant=0 for 4 cycles while issuing continuously -> in_ready drops after STAGES ops accepted, out_res held, all ops later delivered in order.
REQ-037 SHALL test: bne A=4,B=4 -> out_branch_taken=0; beq A=4,B=4 -> 1; flush with 2 ops in flight -> out_valid=0 next edge, no tags emitted.
REQ-038 SHALL test: rst asserted mid-pipeline -> all outputs 0 asynchronously; with ALU_FU_EXT_OPS_EN, sra A=0x80000000,B=4 -> 0xF8000000; without it -> 0.
